ysyx_23060208_rd_arbiter: RTL and testbench

//  2:1 arbiter on the AXI-lite read channels (AR, R) of the shared data SRAM (dsram).

---
 rtl/ysyx_23060208_pkg.sv | 10 +
 rtl/ysyx_23060208_rr_pick2.sv | 10 +
 rtl/ysyx_23060208_rd_arbiter.sv | 73 +++++++
 tb/tb_ysyx_23060208_rd_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_pkg.sv
// ysyx_23060208_pkg: shared encodings for the dsram bus arbiters
package ysyx_23060208_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;
endpackage

// File: rtl/ysyx_23060208_rr_pick2.sv
// ysyx_23060208_rr_pick2: two-way round-robin pick; a tie goes to the master that was not served last
module ysyx_23060208_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);
  assign any = |req;
  assign gnt = &req ? ~last : req[1];
endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// ysyx_23060208_rd_arbiter: 2:1 AXI-lite read arbiter (IFU=m0, LSU=m1) in front of dsram, one transaction at a time
import ysyx_23060208_pkg::*;
module ysyx_23060208_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic                  busy
);
  arb_state_e state, nxt;
  logic grant, last, pick, any, in_a, in_d, d0, d1;
  ysyx_23060208_rr_pick2 u_pick (
    .req ({m1_arvalid, m0_arvalid}),
    .last(last),
    .gnt (pick),
    .any (any)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= MST_IFU;
      last  <= MST_LSU;
    end else begin
      state <= nxt;
      if (state == ARB_IDLE && any) grant <= pick;
      if (state == ARB_DATA && s_rvalid && s_rready) last <= grant;
    end
  end
  always_comb begin
    in_a       = state == ARB_ADDR;
    in_d       = state == ARB_DATA;
    d0         = in_d && grant == MST_IFU;
    d1         = in_d && grant == MST_LSU;
    s_arvalid  = in_a && (grant ? m1_arvalid : m0_arvalid);
    s_araddr   = in_a ? (grant ? m1_araddr : m0_araddr) : '0;
    m0_arready = in_a && grant == MST_IFU && s_arready;
    m1_arready = in_a && grant == MST_LSU && s_arready;
    s_rready   = in_d && (grant ? m1_rready : m0_rready);
    m0_rvalid  = d0 && s_rvalid;
    m1_rvalid  = d1 && s_rvalid;
    m0_rdata   = d0 ? s_rdata : '0;
    m1_rdata   = d1 ? s_rdata : '0;
    m0_rresp   = d0 ? s_rresp : 2'b00;
    m1_rresp   = d1 ? s_rresp : 2'b00;
    busy       = state != ARB_IDLE;
    nxt = state == ARB_IDLE ? (any ? ARB_ADDR : ARB_IDLE) :
          state == ARB_ADDR ? (s_arvalid && s_arready ? ARB_DATA : ARB_ADDR) :
          state == ARB_DATA ? (s_rvalid && s_rready ? ARB_IDLE : ARB_DATA) :
          ARB_IDLE;
  end
endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// tb_ysyx_23060208_rd_arbiter: directed self-checking bench for the dsram read arbiter
module tb_ysyx_23060208_rd_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] m0_araddr = '0, m1_araddr = '0, s_araddr, m0_rdata, m1_rdata, s_rdata = '0;
  logic m0_arvalid = 0, m0_arready, m0_rvalid, m0_rready = 0;
  logic m1_arvalid = 0, m1_arready, m1_rvalid, m1_rready = 0;
  logic [1:0] m0_rresp, m1_rresp, s_rresp = '0;
  logic s_arvalid, s_arready = 0, s_rvalid = 0, s_rready, busy;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  ysyx_23060208_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic addr_phase(input logic g, input logic [31:0] addr);
    chk("addr_busy", 32'(busy), 1);
    chk("addr_s_arvalid", 32'(s_arvalid), 1);
    chk("addr_s_araddr", s_araddr, addr);
    s_arready = 1;
    #1;
    chk("addr_m0_arready", 32'(m0_arready), 32'(!g));
    chk("addr_m1_arready", 32'(m1_arready), 32'(g));
    tick;
    s_arready = 0;
    if (g) m1_arvalid = 0; else m0_arvalid = 0;
  endtask
  task automatic data_phase(input logic g, input logic [31:0] data);
    s_rvalid = 1; s_rdata = data; s_rresp = data[1:0]; m0_rready = 1; m1_rready = 1;
    #1;
    chk("data_s_arvalid", 32'(s_arvalid), 0);
    chk("data_m0_rvalid", 32'(m0_rvalid), 32'(!g));
    chk("data_m1_rvalid", 32'(m1_rvalid), 32'(g));
    chk("data_m0_rdata", m0_rdata, g ? 32'h0 : data);
    chk("data_m1_rdata", m1_rdata, g ? data : 32'h0);
    chk("data_rresp", 32'(g ? m1_rresp : m0_rresp), 32'(data[1:0]));
    chk("data_s_rready", 32'(s_rready), 1);
    tick;
    s_rvalid = 0;
    #1;
    chk("done_busy", 32'(busy), 0);
    chk("done_m0_rvalid", 32'(m0_rvalid), 0);
    chk("done_m1_rvalid", 32'(m1_rvalid), 0);
  endtask
  task automatic run_txn(input logic g, input logic [31:0] addr, input logic [31:0] data);
    tick;
    addr_phase(g, addr);
    data_phase(g, data);
  endtask
  initial begin
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_arvalid", 32'(s_arvalid), 0);
    rst = 0;
    // single IFU read: IDLE sees request, ADDR forwards, DATA returns
    m0_araddr = 32'h8000_0000; m0_arvalid = 1;
    #1;
    chk("idle_s_arvalid", 32'(s_arvalid), 0);
    chk("idle_m0_arready", 32'(m0_arready), 0);
    run_txn(1'b0, 32'h8000_0000, 32'h1234_5678);
    // reset while DATA has a pending response
    m0_araddr = 32'h8000_0008; m0_arvalid = 1;
    tick;
    s_arready = 1;
    tick;
    s_arready = 0; m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; m0_rready = 1;
    #1;
    chk("pre_rst_rvalid", 32'(m0_rvalid), 1);
    rst = 1;
    #1;
    chk("rst_async_s_rready", 32'(s_rready), 0);
    chk("rst_async_busy", 32'(busy), 0);
    tick;
    chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_s_rready", 32'(s_rready), 0);
    chk("rst_busy2", 32'(busy), 0);
    rst = 0; s_rvalid = 0;
    // simultaneous requests alternate, IFU first after reset
    m0_araddr = 32'h8000_0004; m0_arvalid = 1;
    m1_araddr = 32'h8000_0100; m1_arvalid = 1;
    run_txn(1'b0, 32'h8000_0004, 32'h0000_0011);
    m0_arvalid = 1;
    run_txn(1'b1, 32'h8000_0100, 32'h0000_0022);
    m1_arvalid = 1;
    run_txn(1'b0, 32'h8000_0004, 32'h0000_0033);
    run_txn(1'b1, 32'h8000_0100, 32'h0000_0042);
    // dsram stalls AR for 5 cycles with IFU granted and LSU waiting
    m0_arvalid = 1; m1_arvalid = 1;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("stall_s_araddr", s_araddr, 32'h8000_0004);
      chk("stall_m0_arready", 32'(m0_arready), 0);
      chk("stall_m1_arready", 32'(m1_arready), 0);
      tick;
    end
    addr_phase(1'b0, 32'h8000_0004);
    data_phase(1'b0, 32'h0000_0055);
    // LSU holds off R for 3 cycles
    tick;
    addr_phase(1'b1, 32'h8000_0100);
    s_rvalid = 1; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b10; m1_rready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_s_rready", 32'(s_rready), 0);
      chk("hold_m1_rvalid", 32'(m1_rvalid), 1);
      chk("hold_m1_rdata", m1_rdata, 32'hCAFE_F00D);
      chk("hold_m1_rresp", 32'(m1_rresp), 2);
      chk("hold_busy", 32'(busy), 1);
      tick;
    end
    m1_rready = 1;
    #1;
    chk("hold_release_s_rready", 32'(s_rready), 1);
    tick;
    s_rvalid = 0;
    #1;
    chk("hold_done_busy", 32'(busy), 0);
    // lone LSU stream
    for (int i = 0; i < 4; i++) begin
      m1_araddr = 32'h8000_0200 + 32'(4 * i); m1_arvalid = 1;
      run_txn(1'b1, 32'h8000_0200 + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
